word_uart_tx: RTL



---
 rtl/word_uart_tx.sv | 102 ++++++++++
 1 files changed

// File: rtl/word_uart_tx.sv
// Serial transmitter for the 16-bit command link.
// Each word is sent as two back-to-back 8N1 frames, high byte first.
module word_uart_tx #(
  parameter int CLKS_PER_BIT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        tx_valid,
  output logic        tx_rdy,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          byte_idx;
  logic [15:0]   hold;
  logic [7:0]    cur_byte;

  assign cur_byte = byte_idx ? hold[7:0] : hold[15:8];
  assign busy     = ~tx_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_idx  <= 1'b0;
      tx        <= 1'b1;
      tx_rdy    <= 1'b1;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          // tx_rdy is high throughout IDLE, so tx_valid alone marks the accept
          if (tx_valid) begin
            hold     <= data_in;
            byte_idx <= 1'b0;
            state    <= START;
            tx       <= 1'b0;
            tx_rdy   <= 1'b0;
          end
        end
        START: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= cur_byte[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (!byte_idx) begin
              byte_idx <= 1'b1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state  <= IDLE;
              tx_rdy <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
            // set one cycle early so the pulse lands on the final stop cycle
            if (byte_idx && cnt == PRE) word_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
